ps2_ascii_decoder: RTL and testbench
====================================

Name: ps2_ascii_decoder

Overview:
- Converts PS/2 set-2 scan-code bytes from the PS/2 byte receiver into 7-bit ASCII characters plus a one-cycle ready strobe.
- Drives the editor's character-input port (ascii in / ascii ready) directly.
- Tracks make/break, the E0 extended prefix, shift state and caps lock, so the editor only ever sees printable or control characters.

Parameters:
- ENTER_CODE, 7'h0D, ASCII emitted for Enter (main 0x5A and keypad E0 5A).
- BS_CODE, 7'h08, ASCII emitted for Backspace (0x66).

Ports:
- clk  input  1  system clock; all state changes on posedge.
- resetn  input  1  asynchronous, active-low reset.
- scan_code  input  8  scan-code byte from PS/2 receiver; valid only when scan_valid=1.
- scan_valid  input  1  one-cycle strobe; one byte per strobe.
- ascii_out  output  7  last decoded character; held until the next emission.
- ascii_ready  output  1  one-cycle strobe when ascii_out is updated with a new character.
- shift_held  output  1  1 while either shift is down.
- caps_on  output  1  caps-lock toggle state.

Behaviour:
- Reset, asynchronous, active-low: state=IDLE, ascii_out=0, ascii_ready=0, shift_held=0, caps_on=0, internal lshift/rshift/caps_down=0.
- Reset asserted mid-sequence discards any pending prefix.
- FSM states: IDLE, BRK (after F0), EXT (after E0), EXT_BRK (after E0 F0).
- FSM advances only on scan_valid=1.
- Transitions:
  - IDLE: F0->BRK; E0->EXT; else decode make -> IDLE.
  - BRK: any byte = break of that key -> IDLE.
  - EXT: F0->EXT_BRK; E0->EXT; else extended make -> IDLE.
  - EXT_BRK: any byte = extended break -> IDLE.
- Bytes 0xAA, 0xFA, 0xFE, 0xEE, 0x00, 0xFF in any state: ignored, state->IDLE, no emission.
- Modifiers:
  - make 0x12 sets lshift; break 0x12 clears it. Same for 0x59/rshift.
  - shift_held = lshift|rshift.
  - make 0x58 with caps_down=0 toggles caps_on and sets caps_down; repeated 0x58 makes (typematic) do not toggle.
  - break 0x58 clears caps_down.
  - Extended E0 12 (fake shift) is ignored.
- Character decode on non-modifier make in IDLE:
  - letters 0x1C..: a-z; upper case iff shift_held XOR caps_on.
  - digits 0x16,0x1E,0x26,0x25,0x2E,0x36,0x3D,0x3E,0x46,0x45 -> '1'..'9','0'; shifted -> !@#$%^&*().
  - punctuation -_ =+ [{ ]} \| ;: '" ,< .> /? `~ use shift only; caps has no effect.
  - space 0x29->0x20, tab 0x0D->0x09, esc 0x76->0x1B, 0x5A->ENTER_CODE, 0x66->BS_CODE.
  - unmapped codes: no emission.
- Emission:
  - ascii_out updated and ascii_ready=1 in the cycle after the scan_valid cycle (latency 1).
  - ascii_ready=0 otherwise.
- Break codes never emit.
- Typematic repeated makes emit once per byte.
- Shift held across emissions: each make uses the shift/caps state at that byte; the modifier byte updates state before the following byte is decoded.
- Back-to-back scan_valid on consecutive cycles must be supported: each byte processed, ascii_ready may be high on consecutive cycles.

Optional Feature:
- Macro: EXT_NAV_EN.
- Defined: extended makes map as follows, all with emission rules identical to normal characters:
  - E0 75 (up) -> 0x11
  - E0 72 (down) -> 0x12
  - E0 6B (left) -> 0x13
  - E0 74 (right) -> 0x14
  - E0 71 (delete) -> 0x7F
  - E0 6C (home) -> 0x02
  - E0 69 (end) -> 0x03
  - E0 5A -> ENTER_CODE
- Undefined: only E0 5A emits ENTER_CODE; all other extended makes are consumed silently; FSM behaviour otherwise unchanged.

Test Plan:
- Reset, then bytes 1C, F0, 1C -> exactly one ascii_ready pulse with ascii_out=0x61, pulse 1 cycle after 1C strobe; no pulse for F0 1C.
- Bytes 12, 1E, F0, 12, 1E -> outputs 0x40 then 0x32; shift_held 1 after 12, 0 after F0 12.
- Bytes 58, 58, F0, 58, 1C -> caps_on=1 (single toggle despite repeat); output 0x41. Then 12, 1C -> output 0x61 (shift XOR caps).
- Bytes E0, 75 -> EXT_NAV_EN defined: ascii_out=0x11 with pulse; undefined: no pulse. Both builds: E0, F0, 75 -> no pulse, state IDLE.
- Bytes F0, then resetn low 1 cycle, then 1C -> output 0x61 (prefix discarded). Bytes AA, 66 -> AA ignored, output BS_CODE 0x08.
- scan_valid on consecutive cycles with 29, 5A -> ascii_ready high two consecutive cycles, outputs 0x20 then 0x0D.

Source files
------------

// File: rtl/ps2_ascii_decoder.sv
// PS/2 set-2 scan-code to 7-bit ASCII decoder with make/break, E0 prefix, shift and caps-lock tracking.
// Optional build macro EXT_NAV_EN maps extended navigation keys to control codes.
module ps2_ascii_decoder #(
  parameter logic [6:0] ENTER_CODE = 7'h0D,
  parameter logic [6:0] BS_CODE    = 7'h08
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [7:0] scan_code,
  input  logic       scan_valid,
  output logic [6:0] ascii_out,
  output logic       ascii_ready,
  output logic       shift_held,
  output logic       caps_on
);

  typedef enum logic [1:0] {IDLE, BRK, EXT, EXT_BRK} state_t;

  state_t     state_reg, state_next;
  logic       lshift_reg, lshift_next;
  logic       rshift_reg, rshift_next;
  logic       caps_down_reg, caps_down_next;
  logic       caps_on_reg, caps_on_next;
  logic [6:0] ascii_reg, ascii_next;
  logic       ready_reg, ready_next;

  logic       map_hit, map_letter;
  logic [6:0] map_lo, map_hi, map_char;
  logic       ext_hit;
  logic [6:0] ext_char;
  logic       junk_byte;

  assign shift_held  = lshift_reg | rshift_reg;
  assign caps_on     = caps_on_reg;
  assign ascii_out   = ascii_reg;
  assign ascii_ready = ready_reg;

  // Acks, self-test and error bytes from the keyboard never reach the key decoder.
  assign junk_byte = (scan_code == 8'hAA) || (scan_code == 8'hFA) || (scan_code == 8'hFE) ||
                     (scan_code == 8'hEE) || (scan_code == 8'h00) || (scan_code == 8'hFF);

  always_comb begin
    map_hit    = 1'b1;
    map_letter = 1'b0;
    map_lo     = 7'h00;
    map_hi     = 7'h00;
    case (scan_code)
      8'h1C: begin map_letter = 1'b1; map_lo = 7'h61; end
      8'h32: begin map_letter = 1'b1; map_lo = 7'h62; end
      8'h21: begin map_letter = 1'b1; map_lo = 7'h63; end
      8'h23: begin map_letter = 1'b1; map_lo = 7'h64; end
      8'h24: begin map_letter = 1'b1; map_lo = 7'h65; end
      8'h2B: begin map_letter = 1'b1; map_lo = 7'h66; end
      8'h34: begin map_letter = 1'b1; map_lo = 7'h67; end
      8'h33: begin map_letter = 1'b1; map_lo = 7'h68; end
      8'h43: begin map_letter = 1'b1; map_lo = 7'h69; end
      8'h3B: begin map_letter = 1'b1; map_lo = 7'h6A; end
      8'h42: begin map_letter = 1'b1; map_lo = 7'h6B; end
      8'h4B: begin map_letter = 1'b1; map_lo = 7'h6C; end
      8'h3A: begin map_letter = 1'b1; map_lo = 7'h6D; end
      8'h31: begin map_letter = 1'b1; map_lo = 7'h6E; end
      8'h44: begin map_letter = 1'b1; map_lo = 7'h6F; end
      8'h4D: begin map_letter = 1'b1; map_lo = 7'h70; end
      8'h15: begin map_letter = 1'b1; map_lo = 7'h71; end
      8'h2D: begin map_letter = 1'b1; map_lo = 7'h72; end
      8'h1B: begin map_letter = 1'b1; map_lo = 7'h73; end
      8'h2C: begin map_letter = 1'b1; map_lo = 7'h74; end
      8'h3C: begin map_letter = 1'b1; map_lo = 7'h75; end
      8'h2A: begin map_letter = 1'b1; map_lo = 7'h76; end
      8'h1D: begin map_letter = 1'b1; map_lo = 7'h77; end
      8'h22: begin map_letter = 1'b1; map_lo = 7'h78; end
      8'h35: begin map_letter = 1'b1; map_lo = 7'h79; end
      8'h1A: begin map_letter = 1'b1; map_lo = 7'h7A; end
      8'h16: begin map_lo = 7'h31; map_hi = 7'h21; end
      8'h1E: begin map_lo = 7'h32; map_hi = 7'h40; end
      8'h26: begin map_lo = 7'h33; map_hi = 7'h23; end
      8'h25: begin map_lo = 7'h34; map_hi = 7'h24; end
      8'h2E: begin map_lo = 7'h35; map_hi = 7'h25; end
      8'h36: begin map_lo = 7'h36; map_hi = 7'h5E; end
      8'h3D: begin map_lo = 7'h37; map_hi = 7'h26; end
      8'h3E: begin map_lo = 7'h38; map_hi = 7'h2A; end
      8'h46: begin map_lo = 7'h39; map_hi = 7'h28; end
      8'h45: begin map_lo = 7'h30; map_hi = 7'h29; end
      8'h4E: begin map_lo = 7'h2D; map_hi = 7'h5F; end
      8'h55: begin map_lo = 7'h3D; map_hi = 7'h2B; end
      8'h54: begin map_lo = 7'h5B; map_hi = 7'h7B; end
      8'h5B: begin map_lo = 7'h5D; map_hi = 7'h7D; end
      8'h5D: begin map_lo = 7'h5C; map_hi = 7'h7C; end
      8'h4C: begin map_lo = 7'h3B; map_hi = 7'h3A; end
      8'h52: begin map_lo = 7'h27; map_hi = 7'h22; end
      8'h41: begin map_lo = 7'h2C; map_hi = 7'h3C; end
      8'h49: begin map_lo = 7'h2E; map_hi = 7'h3E; end
      8'h4A: begin map_lo = 7'h2F; map_hi = 7'h3F; end
      8'h0E: begin map_lo = 7'h60; map_hi = 7'h7E; end
      8'h29: begin map_lo = 7'h20; map_hi = 7'h20; end
      8'h0D: begin map_lo = 7'h09; map_hi = 7'h09; end
      8'h76: begin map_lo = 7'h1B; map_hi = 7'h1B; end
      8'h5A: begin map_lo = ENTER_CODE; map_hi = ENTER_CODE; end
      8'h66: begin map_lo = BS_CODE; map_hi = BS_CODE; end
      default: map_hit = 1'b0;
    endcase
    if (map_letter)
      map_hi = map_lo ^ 7'h20;
  end

  // Letters follow shift XOR caps; everything else follows shift alone.
  assign map_char = (map_letter ? (shift_held ^ caps_on_reg) : shift_held) ? map_hi : map_lo;

  always_comb begin
    ext_hit  = 1'b1;
    ext_char = 7'h00;
    case (scan_code)
      8'h5A: ext_char = ENTER_CODE;
`ifdef EXT_NAV_EN
      8'h75: ext_char = 7'h11;
      8'h72: ext_char = 7'h12;
      8'h6B: ext_char = 7'h13;
      8'h74: ext_char = 7'h14;
      8'h71: ext_char = 7'h7F;
      8'h6C: ext_char = 7'h02;
      8'h69: ext_char = 7'h03;
`endif
      default: ext_hit = 1'b0;
    endcase
  end

  always_comb begin
    state_next     = state_reg;
    lshift_next    = lshift_reg;
    rshift_next    = rshift_reg;
    caps_down_next = caps_down_reg;
    caps_on_next   = caps_on_reg;
    ascii_next     = ascii_reg;
    ready_next     = 1'b0;
    if (scan_valid) begin
      if (junk_byte) begin
        state_next = IDLE;
      end else begin
        case (state_reg)
          IDLE: begin
            state_next = IDLE;
            if (scan_code == 8'hF0)
              state_next = BRK;
            else if (scan_code == 8'hE0)
              state_next = EXT;
            else if (scan_code == 8'h12)
              lshift_next = 1'b1;
            else if (scan_code == 8'h59)
              rshift_next = 1'b1;
            else if (scan_code == 8'h58) begin
              if (!caps_down_reg) begin
                caps_on_next   = ~caps_on_reg;
                caps_down_next = 1'b1;
              end
            end else if (map_hit) begin
              ascii_next = map_char;
              ready_next = 1'b1;
            end
          end
          BRK: begin
            state_next = IDLE;
            if (scan_code == 8'h12) lshift_next = 1'b0;
            if (scan_code == 8'h59) rshift_next = 1'b0;
            if (scan_code == 8'h58) caps_down_next = 1'b0;
          end
          EXT: begin
            state_next = IDLE;
            if (scan_code == 8'hF0)
              state_next = EXT_BRK;
            else if (scan_code == 8'hE0)
              state_next = EXT;
            else if (ext_hit) begin
              ascii_next = ext_char;
              ready_next = 1'b1;
            end
          end
          default: state_next = IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg     <= IDLE;
      lshift_reg    <= 1'b0;
      rshift_reg    <= 1'b0;
      caps_down_reg <= 1'b0;
      caps_on_reg   <= 1'b0;
      ascii_reg     <= 7'h00;
      ready_reg     <= 1'b0;
    end else begin
      state_reg     <= state_next;
      lshift_reg    <= lshift_next;
      rshift_reg    <= rshift_next;
      caps_down_reg <= caps_down_next;
      caps_on_reg   <= caps_on_next;
      ascii_reg     <= ascii_next;
      ready_reg     <= ready_next;
    end
  end

endmodule

// File: tb/tb_ps2_ascii_decoder.sv
// Randomized and directed bench for ps2_ascii_decoder, checked every cycle against a table-driven keyboard model.
module tb_ps2_ascii_decoder;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic [7:0] scan_code = 8'h00;
  logic       scan_valid = 1'b0;
  logic [6:0] ascii_out;
  logic       ascii_ready;
  logic       shift_held;
  logic       caps_on;

  ps2_ascii_decoder dut (
    .clk(clk), .resetn(resetn), .scan_code(scan_code), .scan_valid(scan_valid),
    .ascii_out(ascii_out), .ascii_ready(ascii_ready), .shift_held(shift_held), .caps_on(caps_on)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic check_en = 1'b0;

  // Keyboard model: key tables plus prefix flags and modifier state.
  logic [6:0] lo_tab [256];
  logic [6:0] hi_tab [256];
  logic       hit_tab [256];
  logic       let_tab [256];
  logic [7:0] letter_codes [26] = '{8'h1C,8'h32,8'h21,8'h23,8'h24,8'h2B,8'h34,8'h33,8'h43,8'h3B,8'h42,8'h4B,8'h3A,
                                    8'h31,8'h44,8'h4D,8'h15,8'h2D,8'h1B,8'h2C,8'h3C,8'h2A,8'h1D,8'h22,8'h35,8'h1A};
  logic [7:0] digit_codes [10] = '{8'h16,8'h1E,8'h26,8'h25,8'h2E,8'h36,8'h3D,8'h3E,8'h46,8'h45};
  logic [7:0] punct_codes [11] = '{8'h4E,8'h55,8'h54,8'h5B,8'h5D,8'h4C,8'h52,8'h41,8'h49,8'h4A,8'h0E};
  logic [7:0] punct_lo [11]    = '{8'h2D,8'h3D,8'h5B,8'h5D,8'h5C,8'h3B,8'h27,8'h2C,8'h2E,8'h2F,8'h60};
  logic [7:0] punct_hi [11]    = '{8'h5F,8'h2B,8'h7B,8'h7D,8'h7C,8'h3A,8'h22,8'h3C,8'h3E,8'h3F,8'h7E};
  logic [7:0] nav_codes [8]    = '{8'h75,8'h72,8'h6B,8'h74,8'h71,8'h6C,8'h69,8'h5A};
  logic [6:0] nav_chars [8]    = '{7'h11,7'h12,7'h13,7'h14,7'h7F,7'h02,7'h03,7'h0D};
  logic [7:0] junk_codes [6]   = '{8'hAA,8'hFA,8'hFE,8'hEE,8'h00,8'hFF};

  logic m_ext, m_brk, m_lsh, m_rsh, m_caps, m_cdown;
  logic [6:0] exp_ascii;
  logic       exp_ready;

  task automatic set_key(input logic [7:0] code, input logic [7:0] lo, input logic [7:0] hi, input logic letter);
    hit_tab[code] = 1'b1;
    lo_tab[code]  = lo[6:0];
    hi_tab[code]  = hi[6:0];
    let_tab[code] = letter;
  endtask

  task automatic build_tables();
    string dlo, dhi;
    dlo = "1234567890";
    dhi = "!@#$%^&*()";
    for (int i = 0; i < 256; i++) begin
      hit_tab[i] = 1'b0; let_tab[i] = 1'b0; lo_tab[i] = 7'h00; hi_tab[i] = 7'h00;
    end
    for (int i = 0; i < 26; i++) set_key(letter_codes[i], 8'(8'h61 + i), 8'(8'h41 + i), 1'b1);
    for (int i = 0; i < 10; i++) set_key(digit_codes[i], dlo[i], dhi[i], 1'b0);
    for (int i = 0; i < 11; i++) set_key(punct_codes[i], punct_lo[i], punct_hi[i], 1'b0);
    set_key(8'h29, 8'h20, 8'h20, 1'b0);
    set_key(8'h0D, 8'h09, 8'h09, 1'b0);
    set_key(8'h76, 8'h1B, 8'h1B, 1'b0);
    set_key(8'h5A, 8'h0D, 8'h0D, 1'b0);
    set_key(8'h66, 8'h08, 8'h08, 1'b0);
  endtask

  task automatic model_reset();
    m_ext = 0; m_brk = 0; m_lsh = 0; m_rsh = 0; m_caps = 0; m_cdown = 0;
    exp_ascii = 7'h00; exp_ready = 1'b0;
  endtask

  task automatic emit(input logic [6:0] c);
    exp_ascii = c;
    exp_ready = 1'b1;
  endtask

  task automatic model_step(input logic [7:0] c);
    logic is_junk, up;
    exp_ready = 1'b0;
    is_junk = 1'b0;
    for (int i = 0; i < 6; i++) if (junk_codes[i] == c) is_junk = 1'b1;
    if (is_junk) begin
      m_ext = 0; m_brk = 0;
    end else if (m_brk) begin
      if (!m_ext && c == 8'h12) m_lsh = 0;
      if (!m_ext && c == 8'h59) m_rsh = 0;
      if (!m_ext && c == 8'h58) m_cdown = 0;
      m_ext = 0; m_brk = 0;
    end else if (c == 8'hF0) begin
      m_brk = 1;
    end else if (c == 8'hE0) begin
      m_ext = 1;
    end else if (m_ext) begin
      m_ext = 0;
      for (int i = 0; i < 8; i++) begin
`ifdef EXT_NAV_EN
        if (nav_codes[i] == c) emit(nav_chars[i]);
`else
        if (nav_codes[i] == c && c == 8'h5A) emit(nav_chars[i]);
`endif
      end
    end else if (c == 8'h12) m_lsh = 1;
    else if (c == 8'h59) m_rsh = 1;
    else if (c == 8'h58) begin
      if (!m_cdown) begin m_caps = ~m_caps; m_cdown = 1; end
    end else if (hit_tab[c]) begin
      up = let_tab[c] ? ((m_lsh | m_rsh) != m_caps) : (m_lsh | m_rsh);
      emit(up ? hi_tab[c] : lo_tab[c]);
    end
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s at %0t: got 0x%02h, expected 0x%02h", name, $time, act, expv);
    end
  endtask

  // Every cycle, outputs must match the model.
  always @(negedge clk) begin
    if (check_en) begin
      chk("ascii_ready", {7'b0, ascii_ready}, {7'b0, exp_ready});
      chk("ascii_out", {1'b0, ascii_out}, {1'b0, exp_ascii});
      chk("shift_held", {7'b0, shift_held}, {7'b0, m_lsh | m_rsh});
      chk("caps_on", {7'b0, caps_on}, {7'b0, m_caps});
    end
  end

  task automatic drive(input logic [7:0] c);
    scan_valid = 1'b1;
    scan_code  = c;
    @(posedge clk); #1;
    model_step(c);
    scan_valid = 1'b0;
    $display("byte 0x%02h -> ready=%0b ascii=0x%02h shift=%0b caps=%0b", c, ascii_ready, ascii_out, shift_held, caps_on);
  endtask

  task automatic idle_cycle();
    scan_valid = 1'b0;
    @(posedge clk); #1;
    exp_ready = 1'b0;
  endtask

  task automatic do_reset();
    scan_valid = 1'b0;
    resetn = 1'b0;
    model_reset();
    @(posedge clk); #1;
    resetn = 1'b1;
    $display("reset pulse");
  endtask

  function automatic logic [7:0] pick();
    int r;
    r = $urandom_range(0, 99);
    if (r < 8)  return 8'hF0;
    if (r < 12) return 8'hE0;
    if (r < 20) begin
      case ($urandom_range(0, 2))
        0: return 8'h12;
        1: return 8'h59;
        default: return 8'h58;
      endcase
    end
    if (r < 24) return junk_codes[$urandom_range(0, 5)];
    if (r < 44) return letter_codes[$urandom_range(0, 25)];
    if (r < 52) return digit_codes[$urandom_range(0, 9)];
    if (r < 60) return punct_codes[$urandom_range(0, 10)];
    if (r < 70) return nav_codes[$urandom_range(0, 7)];
    if (r < 78) begin
      case ($urandom_range(0, 3))
        0: return 8'h29;
        1: return 8'h0D;
        2: return 8'h76;
        default: return 8'h66;
      endcase
    end
    return 8'($urandom_range(0, 255));
  endfunction

  initial begin
    build_tables();
    model_reset();
    resetn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_en = 1'b1;
    chk("reset_ascii_out", {1'b0, ascii_out}, 8'h00);
    chk("reset_ready", {7'b0, ascii_ready}, 8'h00);
    chk("reset_caps", {7'b0, caps_on}, 8'h00);
    resetn = 1'b1;
    idle_cycle();

    // make/break of 'a'
    drive(8'h1C); chk("a_ready", {7'b0, ascii_ready}, 8'h01); chk("a_char", {1'b0, ascii_out}, 8'h61);
    drive(8'hF0); chk("brk_prefix_ready", {7'b0, ascii_ready}, 8'h00);
    drive(8'h1C); chk("brk_a_ready", {7'b0, ascii_ready}, 8'h00);
    idle_cycle();

    // shifted digit
    drive(8'h12); chk("shift_on", {7'b0, shift_held}, 8'h01);
    drive(8'h1E); chk("shift_2", {1'b0, ascii_out}, 8'h40);
    drive(8'hF0); drive(8'h12); chk("shift_off", {7'b0, shift_held}, 8'h00);
    drive(8'h1E); chk("plain_2", {1'b0, ascii_out}, 8'h32);

    // caps lock with typematic repeat
    drive(8'h58); drive(8'h58); drive(8'hF0); drive(8'h58);
    chk("caps_single_toggle", {7'b0, caps_on}, 8'h01);
    drive(8'h1C); chk("caps_A", {1'b0, ascii_out}, 8'h41);
    drive(8'h12); drive(8'h1C); chk("shift_xor_caps", {1'b0, ascii_out}, 8'h61);

    // extended keys
    drive(8'hE0); drive(8'h75);
`ifdef EXT_NAV_EN
    chk("ext_up_ready", {7'b0, ascii_ready}, 8'h01); chk("ext_up_char", {1'b0, ascii_out}, 8'h11);
`else
    chk("ext_up_silent", {7'b0, ascii_ready}, 8'h00);
`endif
    drive(8'hE0); drive(8'hF0); drive(8'h75); chk("ext_brk_silent", {7'b0, ascii_ready}, 8'h00);
    drive(8'h1C); chk("idle_after_ext_brk", {7'b0, ascii_ready}, 8'h01);

    // prefix discarded by reset; junk byte ignored
    drive(8'hF0); do_reset();
    drive(8'h1C); chk("post_reset_a", {1'b0, ascii_out}, 8'h61); chk("post_reset_ready", {7'b0, ascii_ready}, 8'h01);
    drive(8'hAA); chk("junk_silent", {7'b0, ascii_ready}, 8'h00);
    drive(8'h66); chk("backspace", {1'b0, ascii_out}, 8'h08);

    // back-to-back strobes
    drive(8'h29); chk("b2b_space_ready", {7'b0, ascii_ready}, 8'h01); chk("b2b_space", {1'b0, ascii_out}, 8'h20);
    drive(8'h5A); chk("b2b_enter_ready", {7'b0, ascii_ready}, 8'h01); chk("b2b_enter", {1'b0, ascii_out}, 8'h0D);
    idle_cycle();

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 299) == 0) do_reset();
      else if ($urandom_range(0, 9) < 7) drive(pick());
      else idle_cycle();
    end
    idle_cycle();

    check_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
